// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues single-outstanding word reads and buffers results in a prefetch FIFO.
// Optional build macro FETCH_OP_CHECK_EN adds the undefined-opcode flag on the FIFO head.
module fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic                        imem_ack,
    input  logic [31:0]                 imem_rdata,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    input  logic                        stall,
    output logic                        instr_valid,
    output logic [31:0]                 instr,
    output logic [5:0]                  op,
    output logic [ADDR_W-1:0]           instr_pc,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        illegal_op
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [31:0]       instr_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];
    logic              ack;
    logic              pop;
    logic              push;
    logic [CW-1:0]     count_after_pop;
    logic [CW-1:0]     count_after_push;

    assign ack              = imem_req & imem_ack;
    assign pop              = instr_valid & ~stall;
    assign push             = (state == S_WAIT) & ack & ~redirect_valid & ~rst;
    assign count_after_pop  = fifo_count - CW'(pop);
    assign count_after_push = count_after_pop + CW'(1);
    assign target           = redirect_pc & ~ADDR_W'(3);

    // Head outputs read zero whenever the FIFO is empty, giving the defined reset values.
    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? instr_mem[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : '0;
    assign op          = instr[31:26];

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (redirect_valid) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            pc         <= target;
            case (state)
                S_WAIT: begin
                    if (ack) imem_addr <= target;
                    else     state     <= S_DROP;
                end
                S_DROP: begin
                    if (ack) begin
                        state     <= S_WAIT;
                        imem_addr <= target;
                    end
                end
                default: begin
                    state     <= S_WAIT;
                    imem_req  <= 1'b1;
                    imem_addr <= target;
                end
            endcase
        end else begin
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= count_after_pop;
            case (state)
                S_WAIT: begin
                    if (ack) begin
                        wr_ptr     <= wr_ptr + PW'(1);
                        fifo_count <= count_after_push;
                        pc         <= pc + ADDR_W'(4);
                        if (count_after_push < DEPTH_C) begin
                            imem_addr <= pc + ADDR_W'(4);
                        end else begin
                            state    <= S_IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    // Stale read completes; re-issue at the redirect target held in pc.
                    if (ack) begin
                        state     <= S_WAIT;
                        imem_addr <= pc;
                    end
                end
                default: begin
                    if (count_after_pop < DEPTH_C) begin
                        state     <= S_WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
            endcase
        end
    end

    // NOTE: storage arrays carry no reset; instr_valid gates every read of them.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= pc;
        end
    end

`ifdef FETCH_OP_CHECK_EN
    logic ill_mem [FIFO_DEPTH];

    function automatic logic op_illegal(input logic [5:0] code);
        return !(code inside {[6'd0:6'd5], [6'd10:6'd14], 6'd20, 6'd21, 6'd30, 6'd31});
    endfunction

    // Flag is computed at push time so it travels with its FIFO entry.
    always_ff @(posedge clk) begin
        if (push) ill_mem[wr_ptr] <= op_illegal(imem_rdata[31:26]);
    end

    assign illegal_op = instr_valid & ill_mem[rd_ptr];
`else
    assign illegal_op = 1'b0;
`endif

endmodule
